reg_shift_sin_pout: RTL and testbench

- Serial-in/parallel-out receiver for the calculator's serial operand/result link: the receive end of the parallel-load shift transmitter.
- Samples one data bit per rising edge of the link bit clock while the frame-enable line is high, LSB first.
- Assembles WIDTH bits and presents the word to the parallel consumer with a valid/ack handshake.
- All link inputs are asynchronous to clk and are synchronized internally.

---
 rtl/reg_shift_sin_pout.sv | 125 ++++++++++++
 tb/tb_reg_shift_sin_pout.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_shift_sin_pout.sv
// Serial-in/parallel-out link receiver: synchronizes the async bit clock, enable and data,
// assembles WIDTH bits LSB-first and hands the word off via a valid/ack output register.
`timescale 1ns/1ps

module reg_shift_sin_pout_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge reset)
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

module reg_shift_sin_pout #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_clk,
  input  logic             rx_en,
  input  logic             rx_bit,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ack,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);
  localparam int CW = $clog2(WIDTH+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [2:0]       raw, synced;
  logic             clk_s, en_s, bit_s, clk_d, strobe;
  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sreg;

  assign raw = {rx_bit, rx_en, rx_clk};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    reg_shift_sin_pout_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (raw[g]),
      .q     (synced[g])
    );
  end

  assign {bit_s, en_s, clk_s} = synced;
  assign strobe  = clk_s & ~clk_d;
  assign rx_busy = (state == SHIFT);

  always_ff @(posedge clk or posedge reset)
    if (reset) clk_d <= 1'b0;
    else       clk_d <= clk_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      sreg       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (clr_err)               overrun    <= 1'b0;
      if (dout_valid && dout_ack) dout_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (strobe && en_s) begin
            sreg  <= WIDTH'(bit_s);
            count <= CW'(1);
            state <= (WIDTH == 1) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          // enable loss takes priority over a coincident strobe
          if (!en_s) begin
            frame_err <= 1'b1;
            sreg      <= '0;
            count     <= '0;
            state     <= IDLE;
          end else if (strobe) begin
            sreg  <= sreg | (WIDTH'(bit_s) << count);
            count <= count + 1'b1;
            if (count == CW'(WIDTH-1)) state <= DONE;
          end
        end
        DONE: begin
          // a coincident ack frees the output register for the new word
          if (!dout_valid || dout_ack) begin
            dout       <= sreg;
            dout_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          count <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          // swallow the transmitter's trailing edges until the frame enable drops
          if (!en_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_shift_sin_pout.sv
// Scoreboard bench for reg_shift_sin_pout: stimulus pushes expected words, a monitor
// compares them at each accepted handshake; directed checks cover latency and error flags.
`timescale 1ns/1ps

module tb_reg_shift_sin_pout;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, rx_clk, rx_en, rx_bit, dout_ack, clr_err;
  logic [W-1:0] dout;
  logic         dout_valid, rx_busy, frame_err, overrun;

  int           n_cmp = 0;
  int           n_err = 0;
  int           ferr_cnt = 0;
  logic [W-1:0] exp_q[$];

  reg_shift_sin_pout #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_clk     (rx_clk),
    .rx_en      (rx_en),
    .rx_bit     (rx_bit),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ack   (dout_ack),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: handshake is sampled mid-cycle, one half-clock before the accepting edge
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_cnt++;
      if (dout_valid && dout_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h want none", dout);
        end else begin
          chk("word", dout, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_valid(input string nm);
    int t = 0;
    while (!dout_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_valid"}, dout_valid, 1);
  endtask

  task automatic ack_word(input string nm);
    wait_valid(nm);
    @(posedge clk); #1 dout_ack = 1'b1;
    @(posedge clk); #1 dout_ack = 1'b0;
    chk({nm, "_ack_drop"}, dout_valid, 0);
  endtask

  // rx_clk = clk/8; data changes while rx_clk is low
  task automatic send(input logic [W-1:0] w, input int nbits, input int ntrail,
                      input bit lat, input bit ack_in_done, input int rst_at);
    rx_en = 1'b1;
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < nbits + ntrail; i++) begin
      rx_bit = (i < nbits) ? w[i] : 1'b1;
      rx_clk = 1'b0;
      if (i == rst_at) begin
        chk("pre_rst_busy", rx_busy, 1);
        chk("pre_rst_valid", dout_valid, 1);
        chk("pre_rst_overrun", overrun, 1);
        reset = 1'b1;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        reset = 1'b0;
        exp_q.delete();
        break;
      end
      repeat (4) @(posedge clk); #1;
      rx_clk = 1'b1;
      if (lat && i == nbits - 1) begin
        repeat (3) @(posedge clk); #1;
        if (ack_in_done) dout_ack = 1'b1;
        else chk("lat_pre", dout_valid, 0);
        @(posedge clk); #1;
        dout_ack = 1'b0;
        chk("lat_valid", dout_valid, 1);
        chk("lat_busy", rx_busy, 0);
      end else begin
        repeat (4) @(posedge clk); #1;
      end
    end
    rx_clk = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx_en = 1'b0;
    repeat (6) @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, bad;
    logic [W-1:0] d0;
    reset = 1'b1; rx_clk = 1'b0; rx_en = 1'b0; rx_bit = 1'b0;
    dout_ack = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;

    // basic frame with exact latency check
    f0 = ferr_cnt;
    exp_q.push_back(32'hA5A5_0F01);
    send(32'hA5A5_0F01, 32, 0, 1'b1, 1'b0, -1);
    chk("basic_ferr", ferr_cnt - f0, 0);
    ack_word("basic");

    // 33rd trailing edge must not disturb the word
    exp_q.push_back(32'hA5A5_0F01);
    send(32'hA5A5_0F01, 32, 1, 1'b0, 1'b0, -1);
    chk("trail_busy", rx_busy, 0);
    ack_word("trail");

    // abort after 12 bits, then a clean frame
    f0 = ferr_cnt;
    send(32'h0000_0ABC, 12, 0, 1'b0, 1'b0, -1);
    chk("abort_ferr_pulse", ferr_cnt - f0, 1);
    chk("abort_valid", dout_valid, 0);
    exp_q.push_back(32'h0000_FFFF);
    send(32'h0000_FFFF, 32, 0, 1'b0, 1'b0, -1);
    ack_word("post_abort");

    // overrun: second word dropped while first is unacked
    exp_q.push_back(32'h1);
    send(32'h1, 32, 0, 1'b1, 1'b0, -1);
    send(32'h2, 32, 0, 1'b0, 1'b0, -1);
    chk("ovr_dout", dout, 32'h1);
    chk("ovr_flag", overrun, 1);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    chk("ovr_clear", overrun, 0);
    ack_word("ovr");

    // ack coincides with DONE: new word loads, no overrun
    exp_q.push_back(32'h1);
    send(32'h1, 32, 0, 1'b1, 1'b0, -1);
    exp_q.push_back(32'h2);
    send(32'h2, 32, 0, 1'b1, 1'b1, -1);
    chk("coinc_dout", dout, 32'h2);
    chk("coinc_overrun", overrun, 0);
    ack_word("coinc");

    // reset mid-frame with a full output register and overrun set
    exp_q.push_back(32'h3);
    send(32'h3, 32, 0, 1'b0, 1'b0, -1);
    send(32'h4, 32, 0, 1'b0, 1'b0, -1);
    send(32'hDEAD_BEEF, 32, 0, 1'b0, 1'b0, 20);
    exp_q.push_back(32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 32, 0, 1'b1, 1'b0, -1);
    ack_word("post_rst");

    // enable held high with no bit clock
    d0 = dout; bad = 0;
    rx_en = 1'b1;
    repeat (1000) begin
      @(posedge clk); #1;
      if (dout !== d0 || dout_valid || rx_busy || frame_err || overrun) bad++;
    end
    rx_en = 1'b0;
    chk("idle_stable", bad, 0);
    repeat (6) @(posedge clk); #1;

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
